// File: rtl/imem_loader.sv
// imem_loader: program loader that feeds the instruction memory write port.
//
// Accepts a byte stream over a valid/ready handshake. The stream is a 16-bit
// little-endian word count N, then 4*N little-endian instruction bytes, then
// (with IMEM_LOADER_CHECKSUM_EN defined) one XOR checksum byte over the data
// bytes. Each assembled word is written at consecutive word addresses from 0.
// The CPU is held (cpu_hold=1) until a complete program has been loaded.
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds CHK state + accumulator).
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle pulse; begins a session from IDLE/DONE/ERR
//   byte_valid/data   input byte stream
//   byte_ready        loader accepts a byte (HDR0/HDR1/DATA/CHK only)
//   imem_we/waddr/wdata  one-cycle write strobe, address and word
//   cpu_hold          keeps the CPU in reset while high
//   done, error       sticky session outcome flags
module imem_loader #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  // Wide enough to hold N itself (up to 65535) after the final increment.
  localparam int unsigned IdxW = 17;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    StIdle, StHdr0, StHdr1, StData, StChk, StDone, StErr
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StHdr0, StHdr1, StData, StDone, StErr
  } state_e;
`endif

  state_e            state_q, state_d;
  logic [15:0]       count_q, count_d;
  logic [IdxW-1:0]   widx_q, widx_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [23:0]       asm_q, asm_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  logic              xfer;
  logic [15:0]       hdr_n;
  logic              hdr_bad;
  logic [IdxW-1:0]   widx_inc;
  logic              last_word;

  always_comb begin
    byte_ready = (state_q == StHdr0) || (state_q == StHdr1) || (state_q == StData)
`ifdef IMEM_LOADER_CHECKSUM_EN
                 || (state_q == StChk)
`endif
                 ;
  end

  assign xfer      = byte_valid && byte_ready;
  assign hdr_n     = {byte_data, count_q[7:0]};
  assign hdr_bad   = (hdr_n == 16'd0) || (32'(hdr_n) > DEPTH);
  assign widx_inc  = widx_q + IdxW'(1);
  assign last_word = (widx_inc == IdxW'(count_q));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    widx_d  = widx_q;
    bidx_d  = bidx_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    hold_d  = hold_q;
    done_d  = done_q;
    err_d   = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_d   = chk_q;
`endif

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StHdr0;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          widx_d  = '0;
          bidx_d  = '0;
          asm_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d   = '0;
`endif
        end
      end
      StHdr0: begin
        if (xfer) begin
          count_d[7:0] = byte_data;
          state_d      = StHdr1;
        end
      end
      StHdr1: begin
        if (xfer) begin
          count_d[15:8] = byte_data;
          if (hdr_bad) begin
            state_d = StErr;
            err_d   = 1'b1;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (xfer) begin
          bidx_d = bidx_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d  = chk_q ^ byte_data;
`endif
          unique case (bidx_q)
            2'd0: asm_d[7:0]   = byte_data;
            2'd1: asm_d[15:8]  = byte_data;
            2'd2: asm_d[23:16] = byte_data;
            2'd3: begin
              we_d    = 1'b1;
              waddr_d = widx_q[ADDR_W-1:0];
              wdata_d = {byte_data, asm_q};
              widx_d  = widx_inc;
              if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state_d = StChk;
`else
                // Release coincides with the final write pulse.
                state_d = StDone;
                done_d  = 1'b1;
                hold_d  = 1'b0;
`endif
              end
            end
            default: ;
          endcase
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StChk: begin
        if (xfer) begin
          if (byte_data == chk_q) begin
            state_d = StDone;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = StErr;
            err_d   = 1'b1;
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
      widx_q  <= '0;
      bidx_q  <= '0;
      asm_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      widx_q  <= widx_d;
      bidx_q  <= bidx_d;
      asm_q   <= asm_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q   <= chk_d;
`endif
    end
  end

  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = hold_q;
  assign done       = done_q;
  assign error      = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader. The driver pushes each expected
// (address, word) pair as the fourth byte of a word is sent; a monitor pops and
// compares on every imem_we pulse. Session outcomes come from the stream rules.
module tb_imem_loader;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  int checks   = 0;
  int failures = 0;

  logic [ADDR_W+31:0] exp_q[$];
  logic [7:0]         dbytes[4*DEPTH];

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .imem_we   (imem_we),
    .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    logic [ADDR_W+31:0] e;
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                 imem_waddr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("waddr", 32'(imem_waddr), 32'(e[ADDR_W+31:32]));
        check("wdata", imem_wdata, e[31:0]);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    byte_valid = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    int t = 0;
    repeat (gap) begin
      @(negedge clk);
      byte_valid = 1'b0;
    end
    @(negedge clk);
    while (byte_ready !== 1'b1 && t < 20) begin
      byte_valid = 1'b0;
      @(negedge clk);
      t++;
    end
    if (byte_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: got byte_ready=%b expected 1", byte_ready);
      byte_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge clk);
    ok = 1'b1;
  endtask

  // One full session: header n, random (or preset) data, optional checksum
  // flipped by chk_flip, then checks of the final flags.
  task automatic load(input int n, input int maxgap, input logic [7:0] chk_flip,
                      input bit fixed);
    bit         ok;
    bit         bad;
    bit         exp_ok;
    logic [7:0] x = 8'h00;
    logic [15:0] nn = 16'(n);
    pulse_start();
    send_byte(nn[7:0], $urandom_range(0, maxgap), ok);
    if (ok) send_byte(nn[15:8], $urandom_range(0, maxgap), ok);
    bad = (n == 0) || (n > int'(DEPTH));
    if (!bad) begin
      for (int i = 0; i < 4 * n && ok; i++) begin
        if (!fixed) dbytes[i] = 8'($urandom);
        x = x ^ dbytes[i];
        if (i % 4 == 3)
          exp_q.push_back({ADDR_W'(i / 4),
                           dbytes[i], dbytes[i-1], dbytes[i-2], dbytes[i-3]});
        send_byte(dbytes[i], $urandom_range(0, maxgap), ok);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (!bad && ok) send_byte(x ^ chk_flip, $urandom_range(0, maxgap), ok);
    exp_ok = !bad && (chk_flip == 8'h00);
`else
    exp_ok = !bad;
`endif
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("done", 32'(done), 32'(exp_ok));
    check("error", 32'(error), 32'(!exp_ok));
    check("cpu_hold", 32'(cpu_hold), 32'(!exp_ok));
    check("byte_ready_after", 32'(byte_ready), 32'd0);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    bit ok;
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    #12;
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_waddr", 32'(imem_waddr), 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single word: 13 05 50 00 -> 0x00500513 at address 0.
    dbytes[0] = 8'h13; dbytes[1] = 8'h05; dbytes[2] = 8'h50; dbytes[3] = 8'h00;
    load(1, 0, 8'h00, 1'b1);

    load(3, 3, 8'h00, 1'b0);

    // Bad headers, then a good reload.
    load(0, 1, 8'h00, 1'b0);
    load(257, 1, 8'h00, 1'b0);
    load(2, 1, 8'h00, 1'b0);

    // Reset after 5 of 8 data bytes; word 0 has already been written.
    pulse_start();
    send_byte(8'h02, 0, ok);
    send_byte(8'h00, 0, ok);
    for (int i = 0; i < 5; i++) begin
      dbytes[i] = 8'($urandom);
      if (i == 3) exp_q.push_back({ADDR_W'(0), dbytes[3], dbytes[2], dbytes[1], dbytes[0]});
      send_byte(dbytes[i], 0, ok);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("midrst_byte_ready", 32'(byte_ready), 32'd0);
    check("midrst_imem_we", 32'(imem_we), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_error", 32'(error), 32'd0);
    check("midrst_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    load(2, 0, 8'h00, 1'b0);

    repeat (8) load($urandom_range(1, 8), $urandom_range(0, 3), 8'h00, 1'b0);

    // Full-depth program: last address DEPTH-1, no wrap.
    load(int'(DEPTH), 0, 8'h00, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    load(2, 1, 8'h01, 1'b0);
    load(2, 0, 8'h00, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
